axi_wr_slave_mem: RTL and testbench

- Parametrised AXI3 write-channel slave (AW, W and B channels) backed by an internal byte-enabled memory.
- Adds burst address generation for FIXED, INCR and WRAP bursts, protocol error detection reported through BRESP, and configurable data, address and ID widths.
- Serves as the bench-side target for write-path masters. A debug read port lets the testbench inspect memory contents.

---
 rtl/axi_wr_slave_mem_if.sv | 40 ++++
 rtl/axi_wr_slave_mem.sv | 167 ++++++++++++++++
 tb/tb_axi_wr_slave_mem.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_wr_slave_mem_if.sv
// AXI3 write-channel bundle (AW, W, B) shared by the memory slave and its master.
// Valid/ready: a transfer occurs on a rising clk edge where valid and ready are both high;
// the source holds valid and its payload stable until that edge, and ready never waits on valid.
interface axi_wr_slave_mem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4
);
    logic                  awvalid;
    logic                  awready;
    logic [ID_W-1:0]       awid;
    logic [ADDR_W-1:0]     awaddr;
    logic [3:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  wvalid;
    logic                  wready;
    logic [ID_W-1:0]       wid;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  wlast;
    logic                  bvalid;
    logic                  bready;
    logic [ID_W-1:0]       bid;
    logic [1:0]            bresp;

    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize, awburst,
        input  wvalid, wid, wdata, wstrb, wlast,
        input  bready,
        output awready, wready, bvalid, bid, bresp
    );

    modport master (
        output awvalid, awid, awaddr, awlen, awsize, awburst,
        output wvalid, wid, wdata, wstrb, wlast,
        output bready,
        input  awready, wready, bvalid, bid, bresp
    );
endinterface

// File: rtl/axi_wr_slave_mem.sv
// AXI3 write slave with byte-enabled backing memory: one outstanding burst, FIXED/INCR/WRAP
// address generation, protocol errors reported as SLVERR, combinational debug read port.
module axi_wr_slave_mem #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int ID_W      = 4,
    parameter int MEM_DEPTH = 256
) (
    input  logic                         clk,
    input  logic                         resetn,
    axi_wr_slave_mem_if.slave            bus,
    input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
    output logic [DATA_W-1:0]            dbg_rdata,
    output logic [1:0]                   dbg_state
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, RESP = 2'd2} state_t;

    state_t            state_q, state_nxt;
    logic              awready_q, awready_nxt;
    logic              wready_q, wready_nxt;
    logic              bvalid_q, bvalid_nxt;
    logic [ID_W-1:0]   bid_q, bid_nxt;
    logic [1:0]        bresp_q, bresp_nxt;

    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        len_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic [3:0]        beat_q;
    logic              aw_err_q;
    logic              err_q;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic              aw_fire, w_fire, last_beat, id_ok, beat_err, aw_err, mem_we;
    logic [ADDR_W-1:0] aw_bytes, beat_bytes, wrap_mask, addr_nxt;
    logic [IDX_W-1:0]  word_idx;

    assign aw_fire   = bus.awvalid && awready_q;
    assign w_fire    = bus.wvalid && wready_q;
    assign last_beat = (beat_q == len_q);
    assign id_ok     = (bus.wid == id_q);
    assign beat_err  = !id_ok || (bus.wlast != last_beat);
    // A mismatched ID means the beat belongs to nobody we know, so it never reaches memory.
    assign mem_we    = w_fire && !aw_err_q && id_ok;
    assign word_idx  = addr_q[OFF_W +: IDX_W];

    assign aw_bytes = ADDR_W'(1) << bus.awsize;
    assign aw_err   = (bus.awburst == 2'b11)
                   || (aw_bytes > ADDR_W'(STRB_W))
                   || ((bus.awburst == 2'b10) && !(bus.awlen inside {4'd1, 4'd3, 4'd7, 4'd15}))
                   || ((bus.awburst == 2'b10) && ((bus.awaddr & (aw_bytes - ADDR_W'(1))) != '0));

    assign beat_bytes = ADDR_W'(1) << size_q;
    assign wrap_mask  = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);

    always_comb begin
        addr_nxt = addr_q;
        case (burst_q)
            2'b01:   addr_nxt = addr_q + beat_bytes;
            2'b10:   addr_nxt = (addr_q & ~wrap_mask) | ((addr_q + beat_bytes) & wrap_mask);
            default: addr_nxt = addr_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= 2'b00;
        end else begin
            state_q   <= state_nxt;
            awready_q <= awready_nxt;
            wready_q  <= wready_nxt;
            bvalid_q  <= bvalid_nxt;
            bid_q     <= bid_nxt;
            bresp_q   <= bresp_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        awready_nxt = awready_q;
        wready_nxt  = wready_q;
        bvalid_nxt  = bvalid_q;
        bid_nxt     = bid_q;
        bresp_nxt   = bresp_q;
        case (state_q)
            IDLE: begin
                awready_nxt = 1'b1;
                if (aw_fire) begin
                    awready_nxt = 1'b0;
                    wready_nxt  = 1'b1;
                    state_nxt   = DATA;
                end
            end
            DATA: begin
                // Beat count, not wlast, decides where the burst ends.
                if (w_fire && last_beat) begin
                    wready_nxt = 1'b0;
                    bvalid_nxt = 1'b1;
                    bid_nxt    = id_q;
                    bresp_nxt  = (err_q || beat_err) ? 2'b10 : 2'b00;
                    state_nxt  = RESP;
                end
            end
            RESP: begin
                if (bvalid_q && bus.bready) begin
                    bvalid_nxt  = 1'b0;
                    awready_nxt = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            beat_q   <= '0;
            aw_err_q <= 1'b0;
            err_q    <= 1'b0;
        end else if (aw_fire) begin
            id_q     <= bus.awid;
            addr_q   <= bus.awaddr;
            len_q    <= bus.awlen;
            size_q   <= bus.awsize;
            burst_q  <= bus.awburst;
            beat_q   <= '0;
            aw_err_q <= aw_err;
            err_q    <= aw_err;
        end else if (w_fire) begin
            addr_q <= addr_nxt;
            beat_q <= beat_q + 4'd1;
            if (beat_err) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (bus.wstrb[i]) mem[word_idx][i*8 +: 8] <= bus.wdata[i*8 +: 8];
            end
        end
    end

    assign dbg_rdata   = mem[dbg_addr];
    assign dbg_state   = state_q;
    assign bus.awready = awready_q;
    assign bus.wready  = wready_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bid     = bid_q;
    assign bus.bresp   = bresp_q;
endmodule

// File: tb/tb_axi_wr_slave_mem.sv
// Bench for axi_wr_slave_mem: directed protocol scenarios plus random bursts, all checked
// against a byte-level memory model that applies the burst addressing and error rules directly.
module tb_axi_wr_slave_mem;
  logic       clk;
  logic       resetn;
  logic [7:0] dbg_addr;
  logic [31:0] dbg_rdata;
  logic [1:0] dbg_state;

  axi_wr_slave_mem_if #(.DATA_W(32), .ADDR_W(32), .ID_W(4)) bus();

  axi_wr_slave_mem #(.DATA_W(32), .ADDR_W(32), .ID_W(4), .MEM_DEPTH(256)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .dbg_addr  (dbg_addr),
    .dbg_rdata (dbg_rdata),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_mem [256];
  logic [3:0]  b_wid  [16];
  logic [31:0] b_data [16];
  logic [3:0]  b_strb [16];
  logic        b_last [16];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // reference model
  function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    idx = int'((a >> 2) % 256);
    for (int i = 0; i < 4; i++)
      if (s[i]) exp_mem[idx][i*8 +: 8] = d[i*8 +: 8];
  endfunction

  function automatic logic [1:0] model_burst(input logic [3:0] id, input logic [31:0] addr,
                                             input logic [3:0] len, input logic [2:0] size,
                                             input logic [1:0] burst);
    int unsigned nbytes, total, n;
    logic [31:0] a;
    bit aw_err, err;
    nbytes = 32'd1 << size;
    n      = int'(len) + 1;
    total  = n * nbytes;
    aw_err = (burst == 2'b11) || (nbytes > 4) ||
             (burst == 2'b10 && !(n == 2 || n == 4 || n == 8 || n == 16)) ||
             (burst == 2'b10 && (addr % nbytes) != 0);
    err = aw_err;
    a   = addr;
    for (int b = 0; b < int'(n); b++) begin
      if (b_wid[b] != id) err = 1'b1;
      else if (!aw_err) model_write(a, b_data[b], b_strb[b]);
      if (b_last[b] != (b == int'(n) - 1)) err = 1'b1;
      case (burst)
        2'b01:   a = a + nbytes;
        2'b10:   a = (a - (a % total)) + ((a + nbytes) % total);
        default: a = a;
      endcase
    end
    return err ? 2'b10 : 2'b00;
  endfunction

  // drivers (called at a negedge, return at a negedge after the handshake edge)
  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst, output int wait_cyc);
    bit timeout;
    bus.awvalid = 1'b1; bus.awid = id; bus.awaddr = addr;
    bus.awlen = len; bus.awsize = size; bus.awburst = burst;
    timeout = 1'b1; wait_cyc = 0;
    for (int t = 0; t < 200; t++) begin
      if (bus.awready) begin
        @(negedge clk);
        timeout = 1'b0;
        break;
      end
      @(negedge clk);
      wait_cyc++;
    end
    bus.awvalid = 1'b0;
    check("aw_timeout", timeout, 1'b0);
  endtask

  task automatic send_w(input logic [3:0] id, input logic [31:0] data, input logic [3:0] strb,
                        input logic last);
    bit timeout;
    bus.wvalid = 1'b1; bus.wid = id; bus.wdata = data; bus.wstrb = strb; bus.wlast = last;
    timeout = 1'b1;
    for (int t = 0; t < 200; t++) begin
      if (bus.wready) begin
        @(negedge clk);
        timeout = 1'b0;
        break;
      end
      @(negedge clk);
    end
    bus.wvalid = 1'b0;
    check("w_timeout", timeout, 1'b0);
  endtask

  task automatic check_word(input string tag, input int idx, input logic [31:0] exp);
    dbg_addr = idx[7:0];
    #1;
    check(tag, dbg_rdata, exp);
  endtask

  task automatic set_beats(input logic [3:0] id, input logic [3:0] len);
    for (int b = 0; b < 16; b++) begin
      b_wid[b]  = id;
      b_data[b] = $urandom;
      b_strb[b] = 4'hF;
      b_last[b] = (b == int'(len));
    end
  endtask

  task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int gap_max,
                           input int bdelay, output logic [1:0] resp_obs, output int aw_wait);
    logic [1:0] r_exp;
    int gap;
    r_exp = model_burst(id, addr, len, size, burst);
    send_aw(id, addr, len, size, burst, aw_wait);
    for (int b = 0; b <= int'(len); b++) begin
      gap = $urandom_range(gap_max, 0);
      repeat (gap) @(negedge clk);
      send_w(b_wid[b], b_data[b], b_strb[b], b_last[b]);
      if (b < int'(len)) begin
        check("wready_mid", bus.wready, 1'b1);
        check("bvalid_mid", bus.bvalid, 1'b0);
      end
    end
    check("bvalid_after_last", bus.bvalid, 1'b1);
    check("wready_after_last", bus.wready, 1'b0);
    check("bid", bus.bid, id);
    check("bresp", bus.bresp, r_exp);
    resp_obs = bus.bresp;
    repeat (bdelay) begin
      @(negedge clk);
      check("bvalid_hold", bus.bvalid, 1'b1);
      check("bid_hold", bus.bid, id);
      check("bresp_hold", bus.bresp, r_exp);
      check("awready_in_resp", bus.awready, 1'b0);
      check("wready_in_resp", bus.wready, 1'b0);
    end
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    check("bvalid_cleared", bus.bvalid, 1'b0);
    check("awready_back", bus.awready, 1'b1);
  endtask

  initial begin
    logic [1:0]  resp;
    int          aw_wait;
    logic [3:0]  id, len;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          nb, r;

    resetn = 1'b0;
    bus.awvalid = 0; bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
    bus.wvalid = 0; bus.wid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 0;
    dbg_addr = 0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_awready", bus.awready, 1'b0);
    check("rst_wready", bus.wready, 1'b0);
    check("rst_bvalid", bus.bvalid, 1'b0);
    check("rst_bid", bus.bid, 4'h0);
    check("rst_bresp", bus.bresp, 2'b00);
    resetn = 1'b1;
    #1 check("awready_before_edge", bus.awready, 1'b0);
    @(negedge clk);
    check("awready_after_release", bus.awready, 1'b1);

    // zero the whole memory so every word is known to the model
    for (int k = 0; k < 16; k++) begin
      set_beats(4'h0, 4'd15);
      for (int b = 0; b < 16; b++) b_data[b] = 32'h0;
      run_burst(4'h0, 32'(k * 64), 4'd15, 3'd2, 2'b01, 0, 0, resp, aw_wait);
    end

    // 1: INCR 4 beats
    set_beats(4'd5, 4'd3);
    b_data[0] = 32'h11111111; b_data[1] = 32'h22222222; b_data[2] = 32'h33333333; b_data[3] = 32'h44444444;
    run_burst(4'd5, 32'h10, 4'd3, 3'd2, 2'b01, 0, 0, resp, aw_wait);
    check("t1_resp", resp, 2'b00);
    check_word("t1_w4", 4, 32'h11111111);
    check_word("t1_w5", 5, 32'h22222222);
    check_word("t1_w6", 6, 32'h33333333);
    check_word("t1_w7", 7, 32'h44444444);

    // 2: WRAP 4 beats from 0x38
    set_beats(4'd2, 4'd3);
    b_data[0] = 32'hAAAA0001; b_data[1] = 32'hBBBB0002; b_data[2] = 32'hCCCC0003; b_data[3] = 32'hDDDD0004;
    run_burst(4'd2, 32'h38, 4'd3, 3'd2, 2'b10, 0, 0, resp, aw_wait);
    check("t2_resp", resp, 2'b00);
    check_word("t2_w14", 14, 32'hAAAA0001);
    check_word("t2_w15", 15, 32'hBBBB0002);
    check_word("t2_w12", 12, 32'hCCCC0003);
    check_word("t2_w13", 13, 32'hDDDD0004);

    // 3: FIXED with per-beat byte lanes
    set_beats(4'd1, 4'd2);
    b_data[0] = 32'h000000AA; b_data[1] = 32'h0000BB00; b_data[2] = 32'h00CC0000;
    b_strb[0] = 4'h1; b_strb[1] = 4'h2; b_strb[2] = 4'h4;
    run_burst(4'd1, 32'h20, 4'd2, 3'd2, 2'b00, 0, 0, resp, aw_wait);
    check("t3_resp", resp, 2'b00);
    check_word("t3_w8", 8, 32'h00CCBBAA);

    // 4a: early wlast (beat 2) and missing wlast on the final beat
    set_beats(4'd6, 4'd3);
    b_last[2] = 1'b1; b_last[3] = 1'b0;
    run_burst(4'd6, 32'h40, 4'd3, 3'd2, 2'b01, 0, 0, resp, aw_wait);
    check("t4a_resp", resp, 2'b10);
    check_word("t4a_w18", 18, b_data[2]);
    check_word("t4a_w19", 19, b_data[3]);

    // 4b: wid mismatch on beat 1 suppresses that write only
    set_beats(4'd7, 4'd3);
    b_wid[1] = 4'd8;
    run_burst(4'd7, 32'h50, 4'd3, 3'd2, 2'b01, 0, 0, resp, aw_wait);
    check("t4b_resp", resp, 2'b10);
    check_word("t4b_w20", 20, b_data[0]);
    check_word("t4b_w21_untouched", 21, 32'h0);
    check_word("t4b_w22", 22, b_data[2]);

    // 4c: AW-time error (reserved burst) writes nothing
    set_beats(4'd9, 4'd1);
    run_burst(4'd9, 32'h60, 4'd1, 3'd2, 2'b11, 0, 0, resp, aw_wait);
    check("t4c_resp", resp, 2'b10);
    check_word("t4c_w24_untouched", 24, 32'h0);

    // 5: bready held low five cycles, then back-to-back AW
    set_beats(4'd4, 4'd1);
    run_burst(4'd4, 32'h70, 4'd1, 3'd2, 2'b01, 0, 5, resp, aw_wait);
    set_beats(4'd4, 4'd0);
    run_burst(4'd4, 32'h78, 4'd0, 3'd2, 2'b01, 0, 0, resp, aw_wait);
    check("t5_aw_next_cycle", aw_wait, 0);
    check("t5_resp", resp, 2'b00);

    // 6: reset during beat 2 of 4
    set_beats(4'd3, 4'd3);
    send_aw(4'd3, 32'h80, 4'd3, 3'd2, 2'b01, aw_wait);
    send_w(4'd3, b_data[0], 4'hF, 1'b0);
    send_w(4'd3, b_data[1], 4'hF, 1'b0);
    model_write(32'h80, b_data[0], 4'hF);
    model_write(32'h84, b_data[1], 4'hF);
    resetn = 1'b0;
    #1;
    check("t6_awready", bus.awready, 1'b0);
    check("t6_wready", bus.wready, 1'b0);
    check("t6_bvalid", bus.bvalid, 1'b0);
    check("t6_bid", bus.bid, 4'h0);
    check("t6_bresp", bus.bresp, 2'b00);
    @(negedge clk);
    resetn = 1'b1;
    #1 check("t6_awready_pre_edge", bus.awready, 1'b0);
    @(negedge clk);
    check("t6_awready_post_edge", bus.awready, 1'b1);
    check_word("t6_w32", 32, exp_mem[32]);
    check_word("t6_w33", 33, exp_mem[33]);
    check_word("t6_w34_untouched", 34, 32'h0);
    set_beats(4'd3, 4'd3);
    run_burst(4'd3, 32'h80, 4'd3, 3'd2, 2'b01, 0, 0, resp, aw_wait);
    check("t6_resp_after", resp, 2'b00);

    // random bursts against the model
    for (int k = 0; k < 40; k++) begin
      id = 4'($urandom_range(15, 0));
      r  = $urandom_range(9, 0);
      burst = (r < 2) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      size  = ($urandom_range(9, 0) == 0) ? 3'd3 : 3'($urandom_range(2, 0));
      len   = 4'($urandom_range(15, 0));
      if (burst == 2'b10 && $urandom_range(4, 0) != 0) begin
        case ($urandom_range(3, 0))
          0: len = 4'd1;
          1: len = 4'd3;
          2: len = 4'd7;
          default: len = 4'd15;
        endcase
      end
      addr = 32'($urandom_range(1023, 0));
      if (burst == 2'b10 && $urandom_range(4, 0) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
      nb = int'(len) + 1;
      for (int b = 0; b < 16; b++) begin
        b_wid[b]  = ($urandom_range(9, 0) == 0) ? ~id : id;
        b_data[b] = $urandom;
        b_strb[b] = 4'($urandom_range(15, 0));
        b_last[b] = (b == nb - 1) ^ ($urandom_range(11, 0) == 0);
      end
      run_burst(id, addr, len, size, burst, 2, $urandom_range(3, 0), resp, aw_wait);
    end

    // full memory comparison
    for (int i = 0; i < 256; i++) check_word("mem_sweep", i, exp_mem[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
